// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the alignment helpers used by both the control path and the bench.
package lsu_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_e;

    // Encoding 2'b11 behaves as a word access.
    function automatic logic lsu_is_word(input logic [1:0] size);
        return size[1];
    endfunction

    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] lo);
        if (lsu_is_word(size))
            return lo != 2'b00;
        else if (size == SIZE_H)
            return lo[0];
        else
            return 1'b0;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Pipeline request/response handshake plus the word-memory bus of the LSU.
interface load_store_unit_if #(parameter int ADDR_W = 32);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_misaligned;
    logic              mem_wr_enable;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_write_data;
    logic [31:0]       mem_read_data;

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_misaligned,
               mem_wr_enable, mem_addr, mem_write_data
    );

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_misaligned,
               mem_wr_enable, mem_addr, mem_write_data
    );
endinterface

// File: rtl/lsu_byte_lane.sv
// Little-endian lane logic: extracts/extends a load from a word and merges
// right-aligned store data into the lanes selected by size and address.
import lsu_pkg::*;

module lsu_byte_lane (
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        is_byte;
    logic        is_half;

    assign is_byte = (size_i == SIZE_B);
    assign is_half = (size_i == SIZE_H);
    assign half_v  = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];

    always_comb begin
        byte_v = word_i[7:0];
        case (addr_lo_i)
            2'd1:    byte_v = word_i[15:8];
            2'd2:    byte_v = word_i[23:16];
            2'd3:    byte_v = word_i[31:24];
            default: byte_v = word_i[7:0];
        endcase
    end

    always_comb begin
        load_o = word_i;
        if (is_byte)
            load_o = {{24{signed_i & byte_v[7]}}, byte_v};
        else if (is_half)
            load_o = {{16{signed_i & half_v[15]}}, half_v};
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic       hit;
            logic [7:0] src;
            assign hit = is_byte ? (addr_lo_i == LANE)
                       : is_half ? (addr_lo_i[1] == LANE[1]) : 1'b1;
            // Sub-word data is right-aligned, so a halfword feeds lanes from its own two bytes.
            assign src = is_byte ? wdata_i[7:0]
                       : is_half ? wdata_i[8*(gi%2) +: 8] : wdata_i[8*gi +: 8];
            assign merge_o[8*gi +: 8] = hit ? src : word_i[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: captures one request, performs a
// word read and/or write (read-modify-write for sub-word stores), responds.
import lsu_pkg::*;

module load_store_unit #(
    parameter int ADDR_W = 32
) (
    input logic              clk,
    input logic              rst,
    load_store_unit_if.slave bus
);
    lsu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic              we_q, we_d;
    logic              mis_q, mis_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdword_q, rdword_d;
    logic [31:0]       load_word;
    logic [31:0]       merge_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            mem_addr_q <= '0;
            size_q     <= '0;
            signed_q   <= 1'b0;
            we_q       <= 1'b0;
            mis_q      <= 1'b0;
            wdata_q    <= '0;
            rdword_q   <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            mem_addr_q <= mem_addr_d;
            size_q     <= size_d;
            signed_q   <= signed_d;
            we_q       <= we_d;
            mis_q      <= mis_d;
            wdata_q    <= wdata_d;
            rdword_q   <= rdword_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        mem_addr_d = mem_addr_q;
        size_d     = size_q;
        signed_d   = signed_q;
        we_d       = we_q;
        mis_d      = mis_q;
        wdata_d    = wdata_q;
        rdword_d   = rdword_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_d   = bus.req_addr;
                    size_d   = bus.req_size;
                    signed_d = bus.req_signed;
                    we_d     = bus.req_we;
                    wdata_d  = bus.req_wdata;
                    mis_d    = lsu_misaligned(bus.req_size, bus.req_addr[1:0]);
                    if (mis_d) begin
                        state_d = RESP;
                    end else begin
                        // mem_addr only moves for accesses that reach memory.
                        mem_addr_d = {bus.req_addr[ADDR_W-1:2], 2'b00};
                        state_d    = (bus.req_we && lsu_is_word(bus.req_size)) ? WRITE : READ;
                    end
                end
            end
            READ: begin
                rdword_d = bus.mem_read_data;
                state_d  = we_q ? WRITE : RESP;
            end
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Word stores pass through the merge unchanged, so it serves every store size.
    lsu_byte_lane u_lane (
        .word_i    (rdword_q),
        .wdata_i   (wdata_q),
        .addr_lo_i (addr_q[1:0]),
        .size_i    (size_q),
        .signed_i  (signed_q),
        .load_o    (load_word),
        .merge_o   (merge_word)
    );

    assign bus.req_ready       = (state_q == IDLE);
    assign bus.resp_valid      = (state_q == RESP);
    assign bus.resp_misaligned = (state_q == RESP) && mis_q;
    assign bus.resp_rdata      = ((state_q == RESP) && !we_q && !mis_q) ? load_word : 32'd0;
    assign bus.mem_wr_enable   = (state_q == WRITE);
    assign bus.mem_addr        = mem_addr_q;
    assign bus.mem_write_data  = (state_q == WRITE) ? merge_word : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed requests push expected
// responses/memory writes, negedge monitors pop and compare them.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_load = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        mis;
        int          cyc;
    } resp_t;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    resp_t exp_q[$];
    wr_t   wr_q[$];
    logic [31:0] mem [64];

    load_store_unit_if #(.ADDR_W(32)) bus ();

    load_store_unit #(.ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'(i);
        end else if (bus.mem_wr_enable) begin
            mem[bus.mem_addr[7:2]] <= bus.mem_write_data;
        end
    end

    assign bus.mem_read_data = mem[bus.mem_addr[7:2]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Response monitor
    always @(negedge clk) begin
        if (bus.resp_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_resp: got rdata 0x%08h mis %0d at cycle %0d, expected none",
                         bus.resp_rdata, bus.resp_misaligned, cyc);
            end else begin
                resp_t e;
                e = exp_q.pop_front();
                $display("resp %-12s rdata=0x%08h mis=%0d cycle=%0d", e.name,
                         bus.resp_rdata, bus.resp_misaligned, cyc);
                chk({e.name, "_rdata"}, bus.resp_rdata, e.rdata);
                chk({e.name, "_mis"}, 32'(bus.resp_misaligned), 32'(e.mis));
                chk({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Memory write monitor
    always @(negedge clk) begin
        if (bus.mem_wr_enable) begin
            if (wr_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h at cycle %0d, expected none",
                         bus.mem_addr, bus.mem_write_data, cyc);
            end else begin
                wr_t w;
                w = wr_q.pop_front();
                $display("write %-12s addr=0x%08h data=0x%08h cycle=%0d", w.name,
                         bus.mem_addr, bus.mem_write_data, cyc);
                chk({w.name, "_waddr"}, bus.mem_addr, w.addr);
                chk({w.name, "_wdata"}, bus.mem_write_data, w.data);
                chk({w.name, "_wcycle"}, 32'(cyc), 32'(w.cyc));
            end
        end
    end

    task automatic issue(input string name, input logic we, input logic [1:0] size,
                         input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_mis, input int lat,
                         input int wr_lat, input logic [31:0] wr_data, input logic keep);
        int n;
        resp_t e;
        wr_t   w;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_accept: got req_ready 0 for 20 cycles, expected 1", name);
            bus.req_valid = 1'b0;
        end else begin
            e.name  = name;
            e.rdata = exp_rdata;
            e.mis   = exp_mis;
            e.cyc   = cyc + lat;
            exp_q.push_back(e);
            if (wr_lat > 0) begin
                w.name = name;
                w.addr = addr & 32'hFFFF_FFFC;
                w.data = wr_data;
                w.cyc  = cyc + wr_lat;
                wr_q.push_back(w);
            end
            @(posedge clk);
            #1;
            if (!keep) bus.req_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || wr_q.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (exp_q.size() != 0 || wr_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d responses and %0d writes outstanding, expected 0",
                     exp_q.size(), wr_q.size());
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end of test, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst_mem_we", 32'(bus.mem_wr_enable), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_wdata", bus.mem_write_data, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        mem_load = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        //    name          we    size   sgn   addr        wdata         rdata         mis lat wl  wr_data       keep
        issue("ld_w_0c",    1'b0, 2'b10, 1'b0, 32'h0000_000C, 32'h0,        32'h0000_0003, 1'b0, 2, 0, 32'h0,        1'b0);
        issue("st_b_11",    1'b1, 2'b00, 1'b0, 32'h0000_0011, 32'h0000_0080, 32'h0,        1'b0, 3, 2, 32'h0000_8004, 1'b0);
        issue("ld_bs_11",   1'b0, 2'b00, 1'b1, 32'h0000_0011, 32'h0,        32'hFFFF_FF80, 1'b0, 2, 0, 32'h0,        1'b0);
        issue("ld_bu_11",   1'b0, 2'b00, 1'b0, 32'h0000_0011, 32'h0,        32'h0000_0080, 1'b0, 2, 0, 32'h0,        1'b0);
        issue("st_h_13mis", 1'b1, 2'b01, 1'b0, 32'h0000_0013, 32'h0000_1234, 32'h0,        1'b1, 1, 0, 32'h0,        1'b0);
        issue("ld_w_0emis", 1'b0, 2'b10, 1'b0, 32'h0000_000E, 32'h0,        32'h0,         1'b1, 1, 0, 32'h0,        1'b0);
        issue("st_w_20",    1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'hDEAD_BEEF, 32'h0,        1'b0, 2, 1, 32'hDEAD_BEEF, 1'b0);
        issue("ld_w_20",    1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0,        32'hDEAD_BEEF, 1'b0, 2, 0, 32'h0,        1'b0);
        issue("ld_hs_22",   1'b0, 2'b01, 1'b1, 32'h0000_0022, 32'h0,        32'hFFFF_DEAD, 1'b0, 2, 0, 32'h0,        1'b0);
        issue("ld_hu_20",   1'b0, 2'b01, 1'b0, 32'h0000_0020, 32'h0,        32'h0000_BEEF, 1'b0, 2, 0, 32'h0,        1'b0);
        issue("st_h_22",    1'b1, 2'b01, 1'b0, 32'h0000_0022, 32'h0000_1234, 32'h0,        1'b0, 3, 2, 32'h1234_BEEF, 1'b0);
        issue("ld_bs_23",   1'b0, 2'b00, 1'b1, 32'h0000_0023, 32'h0,        32'h0000_0012, 1'b0, 2, 0, 32'h0,        1'b0);
        issue("ld_sz3_20",  1'b0, 2'b11, 1'b0, 32'h0000_0020, 32'h0,        32'h1234_BEEF, 1'b0, 2, 0, 32'h0,        1'b0);
        issue("ld_ws_20",   1'b0, 2'b10, 1'b1, 32'h0000_0020, 32'h0,        32'h1234_BEEF, 1'b0, 2, 0, 32'h0,        1'b0);
        drain();

        // Abort a read-modify-write halfword store while it is in its read cycle.
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_size   = 2'b01;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'h0000_0008;
        bus.req_wdata  = 32'h0000_BEEF;
        chk("abort_ready_before", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_req_ready", 32'(bus.req_ready), 32'd1);
        chk("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("abort_mem_we", 32'(bus.mem_wr_enable), 32'd0);
        chk("abort_mem_addr", bus.mem_addr, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_word2", mem[2], 32'h0000_0002);
        chk("abort_ready_after", 32'(bus.req_ready), 32'd1);
        issue("ld_w_08",    1'b0, 2'b10, 1'b0, 32'h0000_0008, 32'h0,        32'h0000_0002, 1'b0, 2, 0, 32'h0,        1'b0);
        drain();

        // Back-to-back: req_valid stays high between requests.
        issue("b2b_ld_04",  1'b0, 2'b10, 1'b0, 32'h0000_0004, 32'h0,        32'h0000_0001, 1'b0, 2, 0, 32'h0,        1'b1);
        issue("b2b_ld_14",  1'b0, 2'b10, 1'b0, 32'h0000_0014, 32'h0,        32'h0000_0005, 1'b0, 2, 0, 32'h0,        1'b1);
        issue("b2b_st_05",  1'b1, 2'b00, 1'b0, 32'h0000_0005, 32'h0000_00AA, 32'h0,        1'b0, 3, 2, 32'h0000_AA01, 1'b1);
        issue("b2b_ld_04b", 1'b0, 2'b10, 1'b0, 32'h0000_0004, 32'h0,        32'h0000_AA01, 1'b0, 2, 0, 32'h0,        1'b1);
        issue("b2b_ld_10",  1'b0, 2'b00, 1'b0, 32'h0000_0010, 32'h0,        32'h0000_0004, 1'b0, 2, 0, 32'h0,        1'b0);
        drain();
        chk("final_word1", mem[1], 32'h0000_AA01);
        chk("final_word4", mem[4], 32'h0000_8004);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
